// File: rtl/ddr3_ui_master.sv
// Single-outstanding bridge from a 32-bit request/response port to the 256-bit DDR3 user interface.
// Writes are posted as masked line writes; reads fetch a line and return the addressed word.
module ddr3_ui_master #(
  parameter int TIMEOUT        = 1024,
  parameter int DDR_ADDR_WIDTH = 29
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_init_calib_complete,
  input  logic                      i_req_valid,
  output logic                      o_req_ready,
  input  logic                      i_req_wr,
  input  logic [31:0]               i_req_addr,
  input  logic [31:0]               i_req_wdata,
  input  logic [3:0]                i_req_wstrb,
  output logic                      o_resp_valid,
  input  logic                      i_resp_ready,
  output logic [31:0]               o_resp_rdata,
  output logic                      o_resp_err,
  input  logic                      i_ddr_cmd_ready,
  input  logic                      i_ddr_wr_data_ready,
  output logic                      o_ddr_cmd_en,
  output logic                      o_ddr_cmd,
  output logic [DDR_ADDR_WIDTH-1:0] o_ddr_cmd_addr,
  output logic [255:0]              o_ddr_wr_data,
  output logic [31:0]               o_ddr_wr_strb,
  input  logic                      i_ddr_rd_data_valid,
  input  logic [255:0]              i_ddr_rd_data
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RD_WAIT,
    S_RESP
  } state_t;

  state_t                    r_state;
  logic                      r_drain;
  logic [CNT_W-1:0]          r_cnt;
  logic                      r_req_ready;
  logic                      r_resp_valid;
  logic                      r_resp_err;
  logic [31:0]               r_resp_rdata;
  logic                      r_cmd;
  logic [DDR_ADDR_WIDTH-1:0] r_cmd_addr;
  logic [255:0]              r_wr_data;
  logic [31:0]               r_wr_strb;
  logic [2:0]                r_lane;

  logic                      w_accept;
  logic                      w_cmd_en;
  logic                      w_drain_keep;
  logic [31:0]               w_wr_strb;
  logic                      w_unused_addr;

  assign w_accept      = i_req_valid & r_req_ready;
  assign w_cmd_en      = (r_state == S_ISSUE) & i_ddr_cmd_ready & (r_cmd | i_ddr_wr_data_ready);
  assign w_drain_keep  = r_drain & ~i_ddr_rd_data_valid;
  assign w_unused_addr = ^i_req_addr;

  // Byte mask for the line: only the addressed lane may be written, and mask bit 1 means "keep".
  always_comb begin
    w_wr_strb = '1;
    for (int i = 0; i < 8; i++) begin
      if (i_req_addr[4:2] == 3'(i)) begin
        w_wr_strb[i*4 +: 4] = ~i_req_wstrb;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_drain      <= 1'b0;
      r_cnt        <= '0;
      r_req_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
      r_cmd        <= 1'b0;
      r_cmd_addr   <= '0;
      r_wr_data    <= '0;
      r_wr_strb    <= '1;
      r_lane       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_drain <= w_drain_keep;
          if (w_accept) begin
            r_req_ready <= 1'b0;
            r_cmd       <= ~i_req_wr;
            r_cmd_addr  <= {i_req_addr[DDR_ADDR_WIDTH-1:5], 5'b0};
            r_wr_data   <= {8{i_req_wdata}};
            r_wr_strb   <= w_wr_strb;
            r_lane      <= i_req_addr[4:2];
            r_state     <= S_ISSUE;
          end else begin
            r_req_ready <= i_init_calib_complete & ~w_drain_keep;
          end
        end

        S_ISSUE: begin
          r_drain <= w_drain_keep;
          if (w_cmd_en) begin
            if (r_cmd) begin
              r_cnt   <= '0;
              r_state <= S_RD_WAIT;
            end else begin
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b0;
              r_resp_rdata <= '0;
              r_state      <= S_RESP;
            end
          end
        end

        // A line arriving while draining belongs to an earlier timed-out read.
        S_RD_WAIT: begin
          if (i_ddr_rd_data_valid) begin
            if (r_drain) begin
              r_drain <= 1'b0;
              r_cnt   <= '0;
            end else begin
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b0;
              r_resp_rdata <= i_ddr_rd_data[r_lane*32 +: 32];
              r_state      <= S_RESP;
            end
          end else if (r_cnt == CNT_LAST) begin
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b1;
            r_resp_rdata <= '0;
            r_drain      <= 1'b1;
            r_state      <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_RESP: begin
          r_drain <= w_drain_keep;
          if (i_resp_ready) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= i_init_calib_complete & ~w_drain_keep;
            r_state      <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_req_ready    = r_req_ready;
  assign o_resp_valid   = r_resp_valid;
  assign o_resp_err     = r_resp_err;
  assign o_resp_rdata   = r_resp_rdata;
  assign o_ddr_cmd_en   = w_cmd_en;
  assign o_ddr_cmd      = r_cmd;
  assign o_ddr_cmd_addr = r_cmd_addr;
  assign o_ddr_wr_data  = r_wr_data;
  assign o_ddr_wr_strb  = r_wr_strb;

endmodule

// File: tb/tb_ddr3_ui_master.sv
// Self-checking bench for ddr3_ui_master: directed vector table, randomized transactions
// against a spec-level model, and hand-written timeout / drain / reset / calibration sequences.
module tb_ddr3_ui_master;

  localparam int TMO = 16;
  localparam int AW  = 29;

  logic          clk = 1'b0;
  logic          rst;
  logic          calib;
  logic          reqValid;
  logic          reqReady;
  logic          reqWr;
  logic [31:0]   reqAddr;
  logic [31:0]   reqWdata;
  logic [3:0]    reqWstrb;
  logic          respValid;
  logic          respReady;
  logic [31:0]   respRdata;
  logic          respErr;
  logic          cmdReady;
  logic          wdReady;
  logic          cmdEn;
  logic          cmd;
  logic [AW-1:0] cmdAddr;
  logic [255:0]  wrData;
  logic [31:0]   wrStrb;
  logic          rdValid;
  logic [255:0]  rdData;

  int tests = 0;
  int failures = 0;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          cmdDly;
    int          wdDly;
    int          rdDly;
    int          respHold;
    logic [31:0] rdWord;
    logic [31:0] expAddr;
    logic [31:0] expStrb;
    logic [31:0] expRdata;
  } vec_t;

  vec_t tbl[8];

  ddr3_ui_master #(.TIMEOUT(TMO), .DDR_ADDR_WIDTH(AW)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_init_calib_complete(calib),
    .i_req_valid(reqValid),
    .o_req_ready(reqReady),
    .i_req_wr(reqWr),
    .i_req_addr(reqAddr),
    .i_req_wdata(reqWdata),
    .i_req_wstrb(reqWstrb),
    .o_resp_valid(respValid),
    .i_resp_ready(respReady),
    .o_resp_rdata(respRdata),
    .o_resp_err(respErr),
    .i_ddr_cmd_ready(cmdReady),
    .i_ddr_wr_data_ready(wdReady),
    .o_ddr_cmd_en(cmdEn),
    .o_ddr_cmd(cmd),
    .o_ddr_cmd_addr(cmdAddr),
    .o_ddr_wr_data(wrData),
    .o_ddr_wr_strb(wrStrb),
    .i_ddr_rd_data_valid(rdValid),
    .i_ddr_rd_data(rdData)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model: derived directly from the address/strobe rules with plain arithmetic.
  function automatic logic [31:0] modelAddr(input logic [31:0] a);
    return ((a % 32'h2000_0000) / 32) * 32;
  endfunction

  function automatic logic [31:0] modelStrb(input logic [31:0] a, input logic [3:0] s);
    logic [31:0] m;
    int lane;
    m = 32'hFFFF_FFFF;
    lane = (a / 4) % 8;
    for (int b = 0; b < 4; b++) begin
      if (s[b]) m = m - (32'd1 << (lane * 4 + b));
    end
    return m;
  endfunction

  function automatic logic [31:0] modelRdata(input logic [255:0] line, input logic [31:0] a);
    logic [255:0] sh;
    sh = line >> (((a / 4) % 8) * 32);
    return sh[31:0];
  endfunction

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Presents a request and waits (bounded) for the handshake; returns at the negedge after acceptance.
  task automatic applyStimulus(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] wstrb, output bit ok);
    ok = 1'b0;
    reqWr = wr;
    reqAddr = addr;
    reqWdata = wdata;
    reqWstrb = wstrb;
    reqValid = 1'b1;
    for (int w = 0; w < 20; w++) begin
      if (reqReady) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) @(negedge clk);
    reqValid = 1'b0;
    if (!ok) checkOutput("acceptTimeout", 0, 1);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, ".reqReady"}, reqReady, 0);
    checkOutput({tag, ".respValid"}, respValid, 0);
    checkOutput({tag, ".respErr"}, respErr, 0);
    checkOutput({tag, ".respRdata"}, respRdata, 0);
    checkOutput({tag, ".cmdEn"}, cmdEn, 0);
    checkOutput({tag, ".cmd"}, cmd, 0);
    checkOutput({tag, ".cmdAddr"}, cmdAddr, 0);
    checkOutput({tag, ".wrData"}, wrData, 0);
    checkOutput({tag, ".wrStrb"}, wrStrb, 32'hFFFF_FFFF);
  endtask

  task automatic runTxn(input vec_t v, input logic [255:0] line);
    int issueK;
    int bad;
    int pulses;
    bit ok;
    issueK = v.cmdDly + (v.wr ? v.wdDly : 0);
    cmdReady = (v.cmdDly == 0);
    wdReady = ((v.cmdDly + v.wdDly) == 0);
    respReady = 1'b0;
    applyStimulus(v.wr, v.addr, v.wdata, v.wstrb, ok);
    if (!ok) return;
    bad = 0;
    pulses = 0;
    for (int k = 0; k <= issueK; k++) begin
      cmdReady = (k >= v.cmdDly);
      wdReady = (k >= v.cmdDly + v.wdDly);
      #1;
      if (cmdEn) pulses++;
      if (cmdEn !== (k == issueK)) bad++;
      if (cmd !== !v.wr || {3'b0, cmdAddr} !== v.expAddr) bad++;
      if (v.wr && (wrStrb !== v.expStrb || wrData !== {8{v.wdata}})) bad++;
      if (k == issueK) begin
        checkOutput("cmd", cmd, !v.wr);
        checkOutput("cmdAddr", cmdAddr, v.expAddr);
        if (v.wr) begin
          checkOutput("wrStrb", wrStrb, v.expStrb);
          checkOutput("wrData", wrData, {8{v.wdata}});
          respReady = (v.respHold == 0);
        end
      end else begin
        @(negedge clk);
      end
    end
    @(negedge clk);
    cmdReady = 1'b0;
    wdReady = 1'b0;
    #1;
    if (cmdEn) pulses++;
    checkOutput("issueStable", bad, 0);
    checkOutput("cmdPulses", pulses, 1);
    if (!v.wr) begin
      bad = 0;
      for (int d = 0; d < v.rdDly; d++) begin
        if (respValid) bad++;
        @(negedge clk);
      end
      rdValid = 1'b1;
      rdData = line;
      respReady = (v.respHold == 0);
      @(negedge clk);
      rdValid = 1'b0;
      checkOutput("rdQuiet", bad, 0);
    end
    checkOutput("respValid", respValid, 1);
    checkOutput("respErr", respErr, 0);
    checkOutput("respRdata", respRdata, v.expRdata);
    if (v.respHold > 0) begin
      bad = 0;
      for (int h = 0; h < v.respHold; h++) begin
        @(negedge clk);
        if (!respValid || respRdata !== v.expRdata) bad++;
      end
      checkOutput("respHeld", bad, 0);
      respReady = 1'b1;
    end
    @(negedge clk);
    respReady = 1'b0;
    checkOutput("respDone", respValid, 0);
  endtask

  function automatic logic [255:0] buildLine(input logic [31:0] addr, input logic [31:0] word);
    logic [255:0] l;
    int lane;
    lane = (addr / 4) % 8;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = 32'h5A00_0000 + i;
    l[lane*32 +: 32] = word;
    return l;
  endfunction

  initial begin
    vec_t v;
    logic [255:0] line;
    bit ok;
    int bad;

    rst = 1'b1; calib = 1'b1; reqValid = 1'b0; reqWr = 1'b0; reqAddr = '0; reqWdata = '0;
    reqWstrb = '0; respReady = 1'b0; cmdReady = 1'b0; wdReady = 1'b0; rdValid = 1'b0; rdData = '0;

    //              wr  addr           wdata          wstrb   cD wD rD hold rdWord         expAddr        expStrb        expRdata
    tbl[0] = '{1'b1, 32'h0000_0044, 32'hDEAD_BEEF, 4'hF,    0, 0, 0, 1, 32'h0,         32'h40,        32'hFFFF_FF0F, 32'h0};
    tbl[1] = '{1'b1, 32'h0000_001C, 32'hA5A5_5A5A, 4'b0101, 0, 0, 0, 0, 32'h0,         32'h00,        32'hAFFF_FFFF, 32'h0};
    tbl[2] = '{1'b0, 32'h0000_0048, 32'h0,         4'h0,    0, 0, 5, 1, 32'h1234_5678, 32'h40,        32'hFFFF_FFFF, 32'h1234_5678};
    tbl[3] = '{1'b1, 32'h0000_0100, 32'h0BAD_F00D, 4'hF,   10, 3, 0, 2, 32'h0,         32'h100,       32'hFFFF_FFF0, 32'h0};
    tbl[4] = '{1'b1, 32'h0000_0064, 32'h1122_3344, 4'h0,    0, 0, 0, 0, 32'h0,         32'h60,        32'hFFFF_FFFF, 32'h0};
    tbl[5] = '{1'b0, 32'hE000_003C, 32'h0,         4'h0,    2, 4, 0, 0, 32'hCAFE_F00D, 32'h20,        32'hFFFF_FFFF, 32'hCAFE_F00D};
    tbl[6] = '{1'b0, 32'h1FFF_FFE0, 32'h0,         4'h0,    0, 0, 15, 1, 32'h0F0F_0F0F, 32'h1FFF_FFE0, 32'hFFFF_FFFF, 32'h0F0F_0F0F};
    tbl[7] = '{1'b1, 32'h1FFF_FFF8, 32'h89AB_CDEF, 4'b1001, 3, 2, 0, 1, 32'h0,         32'h1FFF_FFE0, 32'hF6FF_FFFF, 32'h0};

    repeat (3) @(negedge clk);
    checkResetState("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      runTxn(tbl[i], buildLine(tbl[i].addr, tbl[i].rdWord));
    end

    for (int i = 0; i < 40; i++) begin
      v.wr = $urandom_range(0, 1);
      v.addr = $urandom;
      v.wdata = $urandom;
      v.wstrb = 4'($urandom_range(0, 15));
      v.cmdDly = $urandom_range(0, 3);
      v.wdDly = $urandom_range(0, 3);
      v.rdDly = $urandom_range(0, 12);
      v.respHold = $urandom_range(0, 2);
      v.rdWord = 32'h0;
      for (int w = 0; w < 8; w++) line[w*32 +: 32] = $urandom;
      v.expAddr = modelAddr(v.addr);
      v.expStrb = modelStrb(v.addr, v.wstrb);
      v.expRdata = v.wr ? 32'h0 : modelRdata(line, v.addr);
      runTxn(v, line);
    end

    // Read timeout, then a late line must be swallowed before the next read is served.
    cmdReady = 1'b1;
    wdReady = 1'b1;
    applyStimulus(1'b0, 32'h0000_02A4, 32'h0, 4'h0, ok);
    #1;
    checkOutput("tmoIssue", cmdEn, 1);
    @(negedge clk);
    cmdReady = 1'b0;
    wdReady = 1'b0;
    bad = 0;
    for (int k = 0; k < TMO; k++) begin
      if (respValid) bad++;
      @(negedge clk);
    end
    checkOutput("tmoQuiet", bad, 0);
    checkOutput("tmoValid", respValid, 1);
    checkOutput("tmoErr", respErr, 1);
    checkOutput("tmoRdata", respRdata, 0);
    respReady = 1'b1;
    @(negedge clk);
    respReady = 1'b0;
    checkOutput("tmoDone", respValid, 0);

    reqWr = 1'b0;
    reqAddr = 32'h0000_0054;
    reqValid = 1'b1;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (reqReady) bad++;
    end
    reqValid = 1'b0;
    checkOutput("drainBlocksAccept", bad, 0);
    rdValid = 1'b1;
    rdData = {8{32'hBAD0_BAD0}};
    @(negedge clk);
    rdValid = 1'b0;
    v = '{1'b0, 32'h0000_0054, 32'h0, 4'h0, 0, 0, 3, 1, 32'h0, 32'h40, 32'hFFFF_FFFF, 32'h0};
    line = buildLine(32'h0000_0054, 32'h600D_DA7A);
    v.expRdata = modelRdata(line, v.addr);
    runTxn(v, line);

    // Reset while waiting for read data abandons the transaction silently.
    cmdReady = 1'b1;
    wdReady = 1'b1;
    applyStimulus(1'b0, 32'h0000_0048, 32'h7777_7777, 4'hF, ok);
    @(negedge clk);
    cmdReady = 1'b0;
    wdReady = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkResetState("midReset");
    rst = 1'b0;
    rdValid = 1'b1;
    rdData = {8{32'h1357_9BDF}};
    @(negedge clk);
    rdValid = 1'b0;
    bad = 0;
    repeat (6) begin
      if (respValid) bad++;
      @(negedge clk);
    end
    checkOutput("noRespAfterReset", bad, 0);

    // Calibration low blocks new requests entirely.
    calib = 1'b0;
    repeat (2) @(negedge clk);
    reqWr = 1'b1;
    reqAddr = 32'h0000_0080;
    reqValid = 1'b1;
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (reqReady || cmdEn) bad++;
    end
    checkOutput("calibLowBlocks", bad, 0);
    reqValid = 1'b0;
    calib = 1'b1;
    @(negedge clk);
    runTxn(tbl[0], buildLine(tbl[0].addr, tbl[0].rdWord));

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
